// File: rtl/gin_stream_feeder.sv
// Purpose: walks a Y-by-X grid of tag pairs, reads cfg_words SRAM words per pair, streams them to GIN with tags.
// Latency: start at T -> first sram_en at T+1, first GIN_valid at T+3; done the cycle after the last handshake.
// Backpressure: 2-entry tagged buffer; reads issue only when a slot is guaranteed, so one word/cycle at GIN_ready=1.
module gin_stream_feeder #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 16,
  parameter int XID_BITS  = 5,
  parameter int YID_BITS  = 5,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] cfg_base_addr,
  input  logic [YID_BITS-1:0]  cfg_num_y,
  input  logic [XID_BITS-1:0]  cfg_num_x,
  input  logic [CNT_BITS-1:0]  cfg_words,
  input  logic [YID_BITS-1:0]  cfg_y_start,
  input  logic [XID_BITS-1:0]  cfg_x_start,
  output logic                 busy,
  output logic                 done,
  output logic                 sram_en,
  output logic [ADDR_BITS-1:0] sram_addr,
  input  logic [DATA_BITS-1:0] sram_rdata,
  output logic                 GIN_valid,
  input  logic                 GIN_ready,
  output logic [DATA_BITS-1:0] GIN_data,
  output logic [YID_BITS-1:0]  tag_Y,
  output logic [XID_BITS-1:0]  tag_X
);

  localparam logic [CNT_BITS-1:0]  W_ONE = 1;
  localparam logic [XID_BITS-1:0]  X_ONE = 1;
  localparam logic [YID_BITS-1:0]  Y_ONE = 1;
  localparam logic [ADDR_BITS-1:0] A_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Latched job configuration (only what the walk still needs after launch)
  logic [YID_BITS-1:0]  num_y_q;
  logic [XID_BITS-1:0]  num_x_q;
  logic [CNT_BITS-1:0]  words_q;
  logic [XID_BITS-1:0]  x_start_q;

  // Walk position: loop counters, running tags and running address
  logic [YID_BITS-1:0]  y_cnt;
  logic [XID_BITS-1:0]  x_cnt;
  logic [CNT_BITS-1:0]  w_cnt;
  logic [YID_BITS-1:0]  ty_cnt;
  logic [XID_BITS-1:0]  tx_cnt;
  logic [ADDR_BITS-1:0] addr_q;

  // Read in flight: its tags ride along until the data comes back
  logic                 inflight;
  logic [YID_BITS-1:0]  pend_ty;
  logic [XID_BITS-1:0]  pend_tx;

  // Two-entry buffer: head drives the GIN port, tail is the skid slot
  logic                 head_vld;
  logic [DATA_BITS-1:0] head_data;
  logic [YID_BITS-1:0]  head_ty;
  logic [XID_BITS-1:0]  head_tx;
  logic                 tail_vld;
  logic [DATA_BITS-1:0] tail_data;
  logic [YID_BITS-1:0]  tail_ty;
  logic [XID_BITS-1:0]  tail_tx;

  logic       pop;
  logic [1:0] slots;
  logic       issue;
  logic       last_w, last_x, last_y, last_issue;
  logic       zero_cfg;
  logic       launch;
  logic       drain_empty;

  assign pop      = head_vld & GIN_ready;
  // Occupancy plus in-flight read; the slot freed by this cycle's pop may be reused immediately
  assign slots    = 2'(head_vld) + 2'(tail_vld) + 2'(inflight);
  assign issue    = (state == S_RUN) && (slots < (2'd2 + 2'(pop)));

  assign last_w     = (w_cnt == words_q - W_ONE);
  assign last_x     = (x_cnt == num_x_q - X_ONE);
  assign last_y     = (y_cnt == num_y_q - Y_ONE);
  assign last_issue = issue & last_w & last_x & last_y;

  assign zero_cfg = (cfg_num_y == '0) | (cfg_num_x == '0) | (cfg_words == '0);
  assign launch   = (state == S_IDLE) & start;

  // Buffer empties by end of this cycle with nothing left to return
  assign drain_empty = !inflight && (!head_vld || (!tail_vld && pop));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = zero_cfg ? S_DONE : S_RUN;
      S_RUN:   if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_empty) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy      = (state == S_RUN) || (state == S_DRAIN);
    done      = (state == S_DONE);
    sram_en   = issue;
    sram_addr = addr_q;
    GIN_valid = head_vld;
    GIN_data  = head_data;
    tag_Y     = head_ty;
    tag_X     = head_tx;
  end

  // Capture configuration at the accepting start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_y_q   <= '0;
      num_x_q   <= '0;
      words_q   <= '0;
      x_start_q <= '0;
    end else if (launch) begin
      num_y_q   <= cfg_num_y;
      num_x_q   <= cfg_num_x;
      words_q   <= cfg_words;
      x_start_q <= cfg_x_start;
    end
  end

  // Grid walk: word innermost, then X, then Y; address simply counts up
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y_cnt  <= '0;
      x_cnt  <= '0;
      w_cnt  <= '0;
      ty_cnt <= '0;
      tx_cnt <= '0;
      addr_q <= '0;
    end else if (launch && !zero_cfg) begin
      y_cnt  <= '0;
      x_cnt  <= '0;
      w_cnt  <= '0;
      ty_cnt <= cfg_y_start;
      tx_cnt <= cfg_x_start;
      addr_q <= cfg_base_addr;
    end else if (issue) begin
      addr_q <= addr_q + A_ONE;
      if (!last_w) begin
        w_cnt <= w_cnt + W_ONE;
      end else begin
        w_cnt <= '0;
        if (!last_x) begin
          x_cnt  <= x_cnt + X_ONE;
          tx_cnt <= tx_cnt + X_ONE;
        end else begin
          x_cnt  <= '0;
          tx_cnt <= x_start_q;
          y_cnt  <= y_cnt + Y_ONE;
          ty_cnt <= ty_cnt + Y_ONE;
        end
      end
    end
  end

  // Track the read in flight and the tags it belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      pend_ty  <= '0;
      pend_tx  <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pend_ty <= ty_cnt;
        pend_tx <= tx_cnt;
      end
    end
  end

  // Buffer update: returning data fills head first, tail shifts forward on pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_vld  <= 1'b0;
      head_data <= '0;
      head_ty   <= '0;
      head_tx   <= '0;
      tail_vld  <= 1'b0;
      tail_data <= '0;
      tail_ty   <= '0;
      tail_tx   <= '0;
    end else if (pop) begin
      if (tail_vld) begin
        head_data <= tail_data;
        head_ty   <= tail_ty;
        head_tx   <= tail_tx;
        if (inflight) begin
          tail_data <= sram_rdata;
          tail_ty   <= pend_ty;
          tail_tx   <= pend_tx;
        end else begin
          tail_vld <= 1'b0;
        end
      end else if (inflight) begin
        head_data <= sram_rdata;
        head_ty   <= pend_ty;
        head_tx   <= pend_tx;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (inflight) begin
      if (!head_vld) begin
        head_vld  <= 1'b1;
        head_data <= sram_rdata;
        head_ty   <= pend_ty;
        head_tx   <= pend_tx;
      end else begin
        tail_vld  <= 1'b1;
        tail_data <= sram_rdata;
        tail_ty   <= pend_ty;
        tail_tx   <= pend_tx;
      end
    end
  end

endmodule

// File: tb/tb_gin_stream_feeder.sv
// Bench for gin_stream_feeder: SRAM model, handshake monitor, and a nested-loop reference of the expected stream.
// Each scenario task launches a job and compares observed streams/timing against the reference.
// GIN_ready is randomized per cycle in the backpressure and random scenarios.
module tb_gin_stream_feeder;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] cfg_base_addr;
  logic [4:0]  cfg_num_y;
  logic [4:0]  cfg_num_x;
  logic [7:0]  cfg_words;
  logic [4:0]  cfg_y_start;
  logic [4:0]  cfg_x_start;
  logic        busy;
  logic        done;
  logic        sram_en;
  logic [15:0] sram_addr;
  logic [31:0] sram_rdata;
  logic        GIN_valid;
  logic        GIN_ready;
  logic [31:0] GIN_data;
  logic [4:0]  tag_Y;
  logic [4:0]  tag_X;

  gin_stream_feeder dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_num_y(cfg_num_y), .cfg_num_x(cfg_num_x),
    .cfg_words(cfg_words), .cfg_y_start(cfg_y_start), .cfg_x_start(cfg_x_start),
    .busy(busy), .done(done), .sram_en(sram_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .GIN_valid(GIN_valid), .GIN_ready(GIN_ready),
    .GIN_data(GIN_data), .tag_Y(tag_Y), .tag_X(tag_X)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Observations
  logic [15:0] obs_addr[$];
  logic [31:0] obs_data[$];
  logic [4:0]  obs_ty[$];
  logic [4:0]  obs_tx[$];
  int issued, accepted, first_en, first_busy, first_vld, last_hs, done_cnt, done_cyc;
  int stab_err, ovf_err;
  logic        prev_stall;
  logic [31:0] prev_data;
  logic [4:0]  prev_ty, prev_tx;

  // Expectations
  logic [15:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic [4:0]  exp_ty[$];
  logic [4:0]  exp_tx[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {a ^ 16'h5A5A, a};
  endfunction

  // SRAM: data for the address strobed last cycle
  always @(posedge clk) if (sram_en) sram_rdata <= mem_word(sram_addr);

  // Monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (sram_en) begin
        obs_addr.push_back(sram_addr);
        issued++;
        if (first_en < 0) first_en = cyc;
      end
      if (busy && first_busy < 0) first_busy = cyc;
      if (GIN_valid && first_vld < 0) first_vld = cyc;
      if (prev_stall && (!GIN_valid || GIN_data !== prev_data || tag_Y !== prev_ty || tag_X !== prev_tx))
        stab_err++;
      if (GIN_valid && GIN_ready) begin
        obs_data.push_back(GIN_data);
        obs_ty.push_back(tag_Y);
        obs_tx.push_back(tag_X);
        accepted++;
        last_hs = cyc;
      end
      if (issued - accepted > 2) ovf_err++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = GIN_valid & !GIN_ready;
      prev_data  = GIN_data;
      prev_ty    = tag_Y;
      prev_tx    = tag_X;
    end
  end

  task automatic clear_obs();
    obs_addr.delete(); obs_data.delete(); obs_ty.delete(); obs_tx.delete();
    issued = 0; accepted = 0; first_en = -1; first_busy = -1; first_vld = -1;
    last_hs = -1; done_cnt = 0; done_cyc = -1; stab_err = 0; ovf_err = 0;
  endtask

  // Reference: address = base + linear pair index * words + k, tags = start + loop index
  task automatic build_exp(input logic [15:0] base, input int ny, input int nx, input int w,
                           input logic [4:0] ys, input logic [4:0] xs);
    exp_addr.delete(); exp_data.delete(); exp_ty.delete(); exp_tx.delete();
    for (int y = 0; y < ny; y++)
      for (int x = 0; x < nx; x++)
        for (int k = 0; k < w; k++) begin
          logic [15:0] a;
          a = base + 16'((y * nx + x) * w + k);
          exp_addr.push_back(a);
          exp_data.push_back(mem_word(a));
          exp_ty.push_back(ys + 5'(y));
          exp_tx.push_back(xs + 5'(x));
        end
  endtask

  // Returns -1 when every observed stream equals the reference, else the first differing index
  function automatic int seq_diff(output string msg);
    msg = "";
    if (obs_addr.size() != exp_addr.size() || obs_data.size() != exp_data.size()) begin
      $sformat(msg, "reads=%0d words=%0d required %0d", obs_addr.size(), obs_data.size(), exp_addr.size());
      return 0;
    end
    for (int i = 0; i < exp_addr.size(); i++) begin
      if (obs_addr[i] !== exp_addr[i] || obs_data[i] !== exp_data[i] ||
          obs_ty[i] !== exp_ty[i] || obs_tx[i] !== exp_tx[i]) begin
        $sformat(msg, "idx %0d got addr=%h data=%h Y=%0d X=%0d required addr=%h data=%h Y=%0d X=%0d",
                 i, obs_addr[i], obs_data[i], obs_ty[i], obs_tx[i],
                 exp_addr[i], exp_data[i], exp_ty[i], exp_tx[i]);
        return i;
      end
    end
    return -1;
  endfunction

  task automatic launch(input logic [15:0] base, input logic [4:0] ny, input logic [4:0] nx,
                        input logic [7:0] w, input logic [4:0] ys, input logic [4:0] xs,
                        output int t);
    @(posedge clk); #1;
    cfg_base_addr = base; cfg_num_y = ny; cfg_num_x = nx; cfg_words = w;
    cfg_y_start = ys; cfg_x_start = xs; start = 1'b1;
    t = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble cfg afterwards: only the accepting start may use it
    cfg_base_addr = 16'($urandom); cfg_num_y = 5'($urandom); cfg_num_x = 5'($urandom);
    cfg_words = 8'($urandom); cfg_y_start = 5'($urandom); cfg_x_start = 5'($urandom);
  endtask

  task automatic wait_done(input int pct, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      GIN_ready = ($urandom_range(0, 99) < pct);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    GIN_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b required 0", done); end
    checks++; if (sram_en !== 1'b0) begin failures++; $display("FAIL reset_sram_en got %b required 0", sram_en); end
    checks++; if (sram_addr !== 16'h0) begin failures++; $display("FAIL reset_sram_addr got %h required 0", sram_addr); end
    checks++; if (GIN_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b required 0", GIN_valid); end
    checks++; if (GIN_data !== 32'h0) begin failures++; $display("FAIL reset_data got %h required 0", GIN_data); end
    checks++; if (tag_Y !== 5'd0) begin failures++; $display("FAIL reset_tag_Y got %0d required 0", tag_Y); end
    checks++; if (tag_X !== 5'd0) begin failures++; $display("FAIL reset_tag_X got %0d required 0", tag_X); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_single_word();
    int t; bit ok; string msg;
    clear_obs(); GIN_ready = 1'b1;
    build_exp(16'h0010, 1, 1, 1, 5'd2, 5'd3);
    launch(16'h0010, 5'd1, 5'd1, 8'd1, 5'd2, 5'd3, t);
    wait_done(100, 50, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout done_cnt=%0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL single_stream %s", msg); end
    checks++; if (first_en != t + 1) begin failures++; $display("FAIL single_first_read cycle %0d required %0d", first_en, t + 1); end
    checks++; if (first_busy != t + 1) begin failures++; $display("FAIL single_busy cycle %0d required %0d", first_busy, t + 1); end
    checks++; if (first_vld != t + 3) begin failures++; $display("FAIL single_valid cycle %0d required %0d", first_vld, t + 3); end
    checks++; if (done_cyc != t + 4) begin failures++; $display("FAIL single_done cycle %0d required %0d", done_cyc, t + 4); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got %b required 0", busy); end
  endtask

  task automatic test_full_grid();
    int t; bit ok; string msg;
    clear_obs(); GIN_ready = 1'b1;
    build_exp(16'h0100, 2, 3, 4, 5'd0, 5'd0);
    launch(16'h0100, 5'd2, 5'd3, 8'd4, 5'd0, 5'd0, t);
    wait_done(100, 200, ok);
    checks++; if (!ok) begin failures++; $display("FAIL grid_timeout done_cnt=%0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL grid_stream %s", msg); end
    checks++; if (first_vld != t + 3) begin failures++; $display("FAIL grid_first_valid cycle %0d required %0d", first_vld, t + 3); end
    checks++; if (last_hs != t + 3 + 23) begin failures++; $display("FAIL grid_back_to_back last word cycle %0d required %0d", last_hs, t + 26); end
    checks++; if (done_cyc != last_hs + 1) begin failures++; $display("FAIL grid_done cycle %0d required %0d", done_cyc, last_hs + 1); end
    checks++; if (tag_Y !== 5'd1 || tag_X !== 5'd2) begin failures++; $display("FAIL grid_hold_tags got Y=%0d X=%0d required Y=1 X=2", tag_Y, tag_X); end
    checks++; if (GIN_valid !== 1'b0 || GIN_data !== mem_word(16'h0117)) begin failures++; $display("FAIL grid_hold_data got valid=%b data=%h required valid=0 data=%h", GIN_valid, GIN_data, mem_word(16'h0117)); end
  endtask

  task automatic test_backpressure();
    int t; bit ok; string msg;
    clear_obs(); GIN_ready = 1'b0;
    build_exp(16'h0100, 2, 3, 4, 5'd7, 5'd9);
    launch(16'h0100, 5'd2, 5'd3, 8'd4, 5'd7, 5'd9, t);
    wait_done(30, 2000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL bp_timeout done_cnt=%0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL bp_stream %s", msg); end
    checks++; if (stab_err != 0) begin failures++; $display("FAIL bp_stable unstable stalled cycles %0d required 0", stab_err); end
    checks++; if (ovf_err != 0) begin failures++; $display("FAIL bp_outstanding over-limit cycles %0d required 0", ovf_err); end
    checks++; if (done_cyc != last_hs + 1) begin failures++; $display("FAIL bp_done cycle %0d required %0d", done_cyc, last_hs + 1); end
  endtask

  task automatic test_wrap();
    int t; bit ok; string msg;
    logic [4:0]  tx2;
    logic [15:0] a2;
    clear_obs(); GIN_ready = 1'b1;
    build_exp(16'hFFFE, 1, 4, 1, 5'd4, 5'd30);
    launch(16'hFFFE, 5'd1, 5'd4, 8'd1, 5'd4, 5'd30, t);
    wait_done(60, 500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL wrap_timeout done_cnt=%0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL wrap_stream %s", msg); end
    tx2 = (obs_tx.size() > 2) ? obs_tx[2] : 5'd31;
    a2  = (obs_addr.size() > 2) ? obs_addr[2] : 16'hFFFF;
    checks++; if (tx2 !== 5'd0) begin failures++; $display("FAIL wrap_tag_X third word X=%0d required 0", tx2); end
    checks++; if (a2 !== 16'h0000) begin failures++; $display("FAIL wrap_addr third read %h required 0000", a2); end
  endtask

  task automatic test_zero_config();
    int t; bit ok;
    clear_obs(); GIN_ready = 1'b1;
    launch(16'h0200, 5'd2, 5'd2, 8'd0, 5'd0, 5'd0, t);
    wait_done(100, 20, ok);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_cyc != t + 1) begin failures++; $display("FAIL zero_done cycle %0d required %0d", done_cyc, t + 1); end
    checks++; if (issued != 0) begin failures++; $display("FAIL zero_reads got %0d required 0", issued); end
    checks++; if (first_vld != -1) begin failures++; $display("FAIL zero_valid seen at cycle %0d required never", first_vld); end
    checks++; if (first_busy != -1) begin failures++; $display("FAIL zero_busy seen at cycle %0d required never", first_busy); end
  endtask

  task automatic test_start_while_busy();
    int t; bit ok; string msg;
    clear_obs(); GIN_ready = 1'b1;
    build_exp(16'h0040, 1, 1, 3, 5'd5, 5'd6);
    launch(16'h0040, 5'd1, 5'd1, 8'd3, 5'd5, 5'd6, t);
    @(posedge clk); #1;
    cfg_base_addr = 16'h0800; cfg_num_y = 5'd3; cfg_num_x = 5'd3; cfg_words = 8'd3;
    cfg_y_start = 5'd1; cfg_x_start = 5'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, 100, ok);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (!ok || done_cnt != 1) begin failures++; $display("FAIL busy_start done pulses %0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL busy_start_stream %s", msg); end
  endtask

  task automatic test_reset_mid_run();
    int t; bit ok; bit hit; string msg;
    clear_obs(); GIN_ready = 1'b1;
    launch(16'h0100, 5'd2, 5'd3, 8'd4, 5'd0, 5'd0, t);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (accepted >= 5) begin hit = 1'b1; break; end
    end
    checks++; if (!hit) begin failures++; $display("FAIL midreset_reach words %0d required 5", accepted); end
    rst = 1'b0;
    #1;
    checks++; if ({busy, done, sram_en, GIN_valid} !== 4'b0 || sram_addr !== 16'h0 || GIN_data !== 32'h0 ||
                  tag_Y !== 5'd0 || tag_X !== 5'd0) begin
      failures++;
      $display("FAIL midreset_outputs busy=%b done=%b en=%b addr=%h valid=%b data=%h Y=%0d X=%0d required all 0",
               busy, done, sram_en, sram_addr, GIN_valid, GIN_data, tag_Y, tag_X);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    clear_obs();
    build_exp(16'h0300, 2, 3, 4, 5'd1, 5'd2);
    launch(16'h0300, 5'd2, 5'd3, 8'd4, 5'd1, 5'd2, t);
    wait_done(70, 1000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midreset_rerun_timeout done_cnt=%0d required 1", done_cnt); end
    checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL midreset_rerun_stream %s", msg); end
  endtask

  task automatic test_random_jobs();
    for (int n = 0; n < 4; n++) begin
      int t; bit ok; string msg;
      logic [15:0] base; logic [4:0] ny, nx, ys, xs; logic [7:0] w; int pct;
      base = 16'($urandom); ny = 5'($urandom_range(1, 3)); nx = 5'($urandom_range(1, 4));
      w = 8'($urandom_range(1, 5)); ys = 5'($urandom); xs = 5'($urandom);
      pct = $urandom_range(20, 100);
      clear_obs(); GIN_ready = 1'b1;
      build_exp(base, int'(ny), int'(nx), int'(w), ys, xs);
      launch(base, ny, nx, w, ys, xs, t);
      wait_done(pct, 3000, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rand%0d_timeout done_cnt=%0d required 1", n, done_cnt); end
      checks++; if (seq_diff(msg) != -1) begin failures++; $display("FAIL rand%0d_stream %s", n, msg); end
      checks++; if (stab_err != 0 || ovf_err != 0) begin failures++; $display("FAIL rand%0d_flow unstable=%0d over=%0d required 0 0", n, stab_err, ovf_err); end
      checks++; if (done_cyc != last_hs + 1) begin failures++; $display("FAIL rand%0d_done cycle %0d required %0d", n, done_cyc, last_hs + 1); end
    end
  endtask

  initial begin
    start = 1'b0; GIN_ready = 1'b1;
    cfg_base_addr = '0; cfg_num_y = '0; cfg_num_x = '0; cfg_words = '0;
    cfg_y_start = '0; cfg_x_start = '0;
    clear_obs();
    test_reset();
    test_single_word();
    test_full_grid();
    test_backpressure();
    test_wrap();
    test_zero_config();
    test_start_while_busy();
    test_reset_mid_run();
    test_random_jobs();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gin_stream_feeder.md
# gin_stream_feeder

Upstream feeder for the global input network: on a `start` command it walks a configured Y-by-X grid of tag pairs, reads `cfg_words` consecutive words per pair from the input-activation SRAM, and presents each word to the GIN master port. Each word carries its `tag_Y`/`tag_X`. A 2-entry tagged buffer absorbs the SRAM's fixed 1-cycle read latency, so the block sustains one word per cycle while `GIN_ready` stays high.

## Interface
Parameters:
- `DATA_BITS`, 32: SRAM word / GIN data width.
- `ADDR_BITS`, 16: SRAM word-address width.
- `XID_BITS`, 5: X tag width.
- `YID_BITS`, 5: Y tag width.
- `CNT_BITS`, 8: width of the word-count config field.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `start`  in  1: 1-cycle launch pulse; sampled only in IDLE.
- `cfg_base_addr`  in  ADDR_BITS: first SRAM word address.
- `cfg_num_y`  in  YID_BITS: number of Y tags.
- `cfg_num_x`  in  XID_BITS: number of X tags.
- `cfg_words`  in  CNT_BITS: words sent per (Y,X) pair.
- `cfg_y_start`  in  YID_BITS: first Y tag.
- `cfg_x_start`  in  XID_BITS: first X tag.
- `busy`  out  1: high from the cycle after an accepted start until `done`.
- `done`  out  1: 1-cycle completion pulse.
- `sram_en`  out  1: read strobe.
- `sram_addr`  out  ADDR_BITS: read address.
- `sram_rdata`  in  DATA_BITS: read data, valid the cycle after `sram_en`.
- `GIN_valid`  out  1: word available.
- `GIN_ready`  in  1: GIN accepts the word.
- `GIN_data`  out  DATA_BITS: word.
- `tag_Y`  out  YID_BITS: Y tag of the current word.
- `tag_X`  out  XID_BITS: X tag of the current word.

## Operation
- States:
  - IDLE: `start` latches all cfg fields and goes to RUN.
  - RUN: issues reads. After the last read issues, goes to DRAIN.
  - DRAIN: waits until the buffer is empty and no read is in flight, then goes to DONE.
  - DONE: asserts `done` for one cycle, then returns to IDLE.
- Zero config: if any of `cfg_num_y`, `cfg_num_x`, or `cfg_words` is 0 at start, go IDLE→DONE. No SRAM read and no `GIN_valid`.
- Issue order is nested: Y outer, X middle, word innermost.
  - Word k of pair (y,x) has address `base + (y*num_x + x)*words + k`, wrapping modulo 2^ADDR_BITS.
  - Its tags are `tag_Y = y_start + y` and `tag_X = x_start + x`, each wrapping modulo its own width.
- Address is a running counter that increments by 1 per issue. No multiplier is used.
- Issue condition: `occupancy + inflight - pop < 2`, where pop = `GIN_valid & GIN_ready` this cycle.
- Tags are stored per buffer entry alongside the data and travel with the read.
- `tag_Y`/`tag_X` always reflect the head entry. When the buffer is empty they hold the last values.
- `start` while `busy` is ignored. cfg inputs are ignored except at the accepting start.

## Timing
- Reset values: `busy`=0, `done`=0, `sram_en`=0, `sram_addr`=0, `GIN_valid`=0, `GIN_data`=0, `tag_Y`=0, `tag_X`=0. Buffer is empty, state is IDLE.
- Start accepted at cycle T:
  - `busy` and the first `sram_en` at T+1.
  - Data written into the buffer at the end of T+2.
  - First `GIN_valid` at T+3.
- Throughput: with `GIN_ready` held at 1, one word per cycle back-to-back.
- Valid/ready rules:
  - Once `GIN_valid` is high, it and `GIN_data`/tags stay stable until the cycle `GIN_ready`=1.
  - `GIN_valid` never depends combinationally on `GIN_ready`.
- Simultaneous write and pop with a full buffer is legal; occupancy is unchanged.
- The buffer never overflows. A read issued while `GIN_ready`=0 always has a free slot.
- `done` fires the cycle after the last handshake. `busy` drops in the same cycle `done` rises.
- Reset mid-operation clears the state, counters, buffer, and in-flight flag immediately. SRAM data returning after reset is discarded.

## Test plan
- Single word: base=0x0010, num_y=1, num_x=1, words=1, y_start=2, x_start=3, ready=1 -> one read at 0x0010; one `GIN_valid` at T+3 with tag_Y=2, tag_X=3; `done` at T+4.
- Full grid: num_y=2, num_x=3, words=4, base=0x100, ready=1 -> 24 contiguous words on consecutive cycles; tags (0,0)×4, (0,1)×4, … (1,2)×4; addresses 0x100–0x117.
- Backpressure: same grid, `GIN_ready` random at 30% -> no dropped or duplicated words; data and tags are stable while stalled; at most 2 reads are outstanding beyond the accepted words.
- Wrap: x_start=30, num_x=4, XID_BITS=5 -> tag_X sequence 30, 31, 0, 1. base=0xFFFE with 4 words -> addresses FFFE, FFFF, 0000, 0001.
- Zero config: words=0 -> `done` at T+1; `sram_en` and `GIN_valid` never assert. A second `start` while `busy` is ignored.
- Reset mid-run: assert `rst` low at word 5 of 24 -> all outputs return to their reset values within the same cycle; a new `start` after release runs the full sequence cleanly.
